i2c_master_ctrl: RTL

- Byte-level I2C bus master that drives the secure EEPROM's SCL/SDA pins from a simple command/response interface owned by the CPU-side SFR glue.
- Converts START / STOP / WRITE-byte / READ-byte commands into quarter-phase SCL/SDA waveforms.
- Samples the returned SDA and reports slave ACK/NACK and read data.
- Sits directly upstream of the EEPROM: o_i2c_scl/o_i2c_sda feed its inputs; its SDA output, wire-ANDed with ours at top level, returns on i_i2c_sda.

---
 rtl/i2c_master_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master for the secure EEPROM link.
// Turns START/STOP/WRITE/READ commands into quarter-phase SCL/SDA waveforms.
// Each quarter lasts CLK_DIV cycles. A bit slot is four quarters:
//   q0 SCL low, SDA held; q1 SCL low, SDA new; q2/q3 SCL high.
// SCL/SDA are registered. They are computed from the next state and
// quarter, so they change on the same edge as the FSM.
// Optional macro I2C_MASTER_BUS_CHECK_EN turns on the bus-contention flag
// reported on o_rsp_err. Without it, o_rsp_err is tied low.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_nack,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_ack,
  output logic       o_rsp_err,
  output logic       o_bus_active,
  output logic       o_i2c_scl,
  output logic       o_i2c_sda,
  input  logic       i_i2c_sda
);

  typedef enum logic [2:0] {IDLE, START, STOP, BIT, ACKBIT, RESP} state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd3;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] qtr, qtr_nx;
  logic [2:0] bit_idx, bit_nx;
  logic [7:0] sh;
  logic       is_read, nack_q, samp;
  logic       scl_nx, sda_nx, slot_val;
  logic       accept, q_end, slot_end, samp_now;

  assign accept      = (state == IDLE) && i_cmd_valid;
  assign q_end       = (cnt == DIV_LAST);
  assign slot_end    = q_end && (qtr == 2'd3);
  assign samp_now    = q_end && (qtr == 2'd2) && (state == BIT || state == ACKBIT);
  assign o_cmd_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

  // Value driven on SDA during q1..q3 of the slot being entered.
  // Read data slots release the line. The ACK slot releases for WRITE and
  // drives the requested ACK/NACK for READ.
  always_comb begin
    slot_val = 1'b1;
    if (state_nx == BIT)         slot_val = is_read ? 1'b1 : sh[7];
    else if (state_nx == ACKBIT) slot_val = is_read ? nack_q : 1'b1;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, quarter/bit counters, and next SCL/SDA levels.
  always_comb begin
    state_nx = state;
    cnt_nx   = 8'd0;
    qtr_nx   = 2'd0;
    bit_nx   = 3'd0;
    scl_nx   = o_i2c_scl;
    sda_nx   = o_i2c_sda;
    case (state)
      IDLE: if (i_cmd_valid) begin
        case (i_cmd)
          CMD_START: state_nx = START;
          CMD_STOP:  state_nx = STOP;
          default:   state_nx = BIT;
        endcase
      end
      START, STOP: if (slot_end) state_nx = IDLE;
      BIT:         if (slot_end && bit_idx == 3'd7) state_nx = ACKBIT;
      ACKBIT:      if (slot_end) state_nx = RESP;
      RESP:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
    if (state == START || state == STOP || state == BIT || state == ACKBIT) begin
      cnt_nx = q_end ? 8'd0 : cnt + 8'd1;
      qtr_nx = q_end ? qtr + 2'd1 : qtr;
      bit_nx = (state == BIT && slot_end) ? bit_idx + 3'd1 : bit_idx;
    end
    case (state_nx)
      START: case (qtr_nx)
        2'd0:    sda_nx = 1'b1;
        2'd1:    begin scl_nx = 1'b1; sda_nx = 1'b1; end
        2'd2:    begin scl_nx = 1'b1; sda_nx = 1'b0; end
        default: begin scl_nx = 1'b0; sda_nx = 1'b0; end
      endcase
      STOP: case (qtr_nx)
        2'd0:    begin scl_nx = 1'b0; sda_nx = 1'b0; end
        2'd1:    begin scl_nx = 1'b1; sda_nx = 1'b0; end
        default: begin scl_nx = 1'b1; sda_nx = 1'b1; end
      endcase
      BIT, ACKBIT: begin
        scl_nx = qtr_nx[1];
        if (qtr_nx != 2'd0) sda_nx = slot_val;
      end
      RESP:    scl_nx = 1'b0;
      default: ;
    endcase
  end

  // Datapath: counters, pins, command capture, shift register, and response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt          <= 8'd0;
      qtr          <= 2'd0;
      bit_idx      <= 3'd0;
      o_i2c_scl    <= 1'b1;
      o_i2c_sda    <= 1'b1;
      sh           <= 8'd0;
      is_read      <= 1'b0;
      nack_q       <= 1'b0;
      samp         <= 1'b0;
      o_rsp_data   <= 8'd0;
      o_rsp_ack    <= 1'b0;
      o_bus_active <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      qtr       <= qtr_nx;
      bit_idx   <= bit_nx;
      o_i2c_scl <= scl_nx;
      o_i2c_sda <= sda_nx;
      if (accept) begin
        sh      <= i_cmd_data;
        is_read <= (i_cmd == CMD_READ);
        nack_q  <= i_cmd_nack;
      end else if (samp_now) begin
        samp <= i_i2c_sda;
      end
      // Shift only at slot end, so sh[7] stays stable while SCL is high.
      if (state == BIT && slot_end) sh <= {sh[6:0], samp};
      if (state == ACKBIT && slot_end) begin
        o_rsp_ack <= is_read ? ~nack_q : ~samp;
        if (is_read) o_rsp_data <= sh;
      end
      if (state == START && slot_end) o_bus_active <= 1'b1;
      if (state == STOP && slot_end)  o_bus_active <= 1'b0;
    end
  end

`ifdef I2C_MASTER_BUS_CHECK_EN
  logic err_flag;

  // Flag a released data bit that reads back low, and report it at RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_flag  <= 1'b0;
      o_rsp_err <= 1'b0;
    end else begin
      if (accept) err_flag <= 1'b0;
      else if (state == BIT && !is_read && samp_now && o_i2c_sda && !i_i2c_sda)
        err_flag <= 1'b1;
      if (state == ACKBIT && slot_end) o_rsp_err <= err_flag;
    end
  end
`else
  assign o_rsp_err = 1'b0;
`endif

endmodule
